// File: rtl/bwc_pkg.sv
// Shared helpers for the streaming bus width converter: lane-count and lane-placement arithmetic
// plus the width-ratio legality test used at elaboration.
package bwc_pkg;

    function automatic int bwc_lanes(input int size_in, input int size_out);
        return (size_out > size_in) ? size_out / size_in : size_in / size_out;
    endfunction

    // Bit position of the LSB of a narrow lane inside the wide word.
    function automatic int lane_slice_lsb(input int lane, input int lanes, input int width,
                                          input bit le);
        return le ? lane * width : (lanes - 1 - lane) * width;
    endfunction

    function automatic bit bwc_ratio_ok(input int size_in, input int size_out);
        int hi;
        int lo;
        hi = (size_in > size_out) ? size_in : size_out;
        lo = (size_in > size_out) ? size_out : size_in;
        return (lo > 0) && (hi % lo == 0) && (hi / lo >= 2);
    endfunction

endpackage

// File: rtl/bus_width_convert.sv
// Valid/ready width converter: packs narrow beats into wide words (upsize) or unpacks wide
// words into narrow beats (downsize), carrying last and lane-keep framing across the boundary.
module bus_width_convert
    import bwc_pkg::*;
#(
    parameter int   SIZE_IN       = 8,
    parameter int   SIZE_OUT      = 32,
    parameter bit   LITTLE_ENDIAN = 1'b0,
    localparam int  LANES         = bwc_lanes(SIZE_IN, SIZE_OUT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic [SIZE_IN-1:0]  data_in,
    input  logic [LANES-1:0]    input_keep,
    input  logic                input_last,
    output logic                output_valid,
    input  logic                output_ready,
    output logic [SIZE_OUT-1:0] data_out,
    output logic [LANES-1:0]    output_keep,
    output logic                output_last
);

    localparam int CNT_W = $clog2(LANES);

    if (!bwc_ratio_ok(SIZE_IN, SIZE_OUT)) begin : g_bad_ratio
        $fatal(1, "bus_width_convert: SIZE_IN/SIZE_OUT must form an integer ratio >= 2");
    end

    if (SIZE_OUT > SIZE_IN) begin : g_upsize
        logic [SIZE_OUT-1:0] acc;
        logic [SIZE_OUT-1:0] acc_next;
        logic [CNT_W-1:0]    lane_cnt;
        logic [LANES-1:0]    keep_next;
        logic [SIZE_OUT-1:0] data_q;
        logic [LANES-1:0]    keep_q;
        logic                last_q;
        logic                valid_q;
        logic                completing;
        logic                accept;
        logic                unused_keep;

        assign unused_keep = ^input_keep;
        assign completing  = (lane_cnt == CNT_W'(LANES - 1)) || input_last;
        // Only a completing beat needs the output register; it may still go if the sink drains.
        assign input_ready = reset && !(completing && valid_q && !output_ready);
        assign accept      = input_valid && input_ready;

        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        always_comb begin
            acc_next  = acc;
            keep_next = '0;
            for (int i = 0; i < LANES; i++) begin
                if (lane_cnt == CNT_W'(i)) begin
                    acc_next[lane_slice_lsb(i, LANES, SIZE_IN, LITTLE_ENDIAN) +: SIZE_IN] = data_in;
                end
                keep_next[i] = (CNT_W'(i) <= lane_cnt);
            end
        end

        // NOTE: state updates use <= so each register sees pre-edge values of its neighbours.
        always_ff @(posedge clk) begin
            // NOTE: the accumulator is plain flops and is cleared so a reset drops any partial word.
            if (!reset) begin
                acc      <= '0;
                lane_cnt <= '0;
                data_q   <= '0;
                keep_q   <= '0;
                last_q   <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                if (accept) begin
                    if (completing) begin
                        acc      <= '0;
                        lane_cnt <= '0;
                        data_q   <= acc_next;
                        keep_q   <= keep_next;
                        last_q   <= input_last;
                    end else begin
                        acc      <= acc_next;
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                if (accept && completing) begin
                    valid_q <= 1'b1;
                end else if (output_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end

        assign output_valid = valid_q;
        assign data_out     = data_q;
        assign output_keep  = keep_q;
        assign output_last  = last_q;

    end else begin : g_downsize
        logic [SIZE_IN-1:0]  hold_data;
        logic [LANES-1:0]    hold_keep;
        logic [LANES:0]      keep_ext;
        logic                hold_last;
        logic                holding;
        logic [CNT_W-1:0]    lane_ptr;
        logic                at_top;
        logic                accept;
        logic [SIZE_OUT-1:0] lane_data;

        // Keep is contiguous from lane 0, so the top kept lane is the one whose successor is clear.
        assign keep_ext = {1'b0, hold_keep};

        always_comb begin
            at_top    = 1'b0;
            lane_data = '0;
            for (int i = 0; i < LANES; i++) begin
                if (lane_ptr == CNT_W'(i)) begin
                    lane_data = hold_data[lane_slice_lsb(i, LANES, SIZE_OUT, LITTLE_ENDIAN) +: SIZE_OUT];
                    at_top    = !keep_ext[i+1];
                end
            end
        end

        assign input_ready = reset && (!holding || (output_ready && at_top));
        assign accept      = input_valid && input_ready;

        always_ff @(posedge clk) begin
            if (!reset) begin
                hold_data <= '0;
                hold_keep <= '0;
                hold_last <= 1'b0;
                holding   <= 1'b0;
                lane_ptr  <= '0;
            end else if (accept) begin
                holding   <= |input_keep;
                hold_data <= data_in;
                hold_keep <= input_keep;
                hold_last <= input_last;
                lane_ptr  <= '0;
            end else if (holding && output_ready) begin
                if (at_top) begin
                    holding <= 1'b0;
                end else begin
                    lane_ptr <= lane_ptr + 1'b1;
                end
            end
        end

        assign output_valid = holding;
        assign data_out     = lane_data;
        assign output_last  = holding && hold_last && at_top;
        // Every emitted narrow beat is a full lane; the mask reads zero only when idle.
        assign output_keep  = {LANES{holding}};
    end

endmodule
